mem_port_arbiter: RTL and testbench

- Arbitrates one single-port unified memory between instruction fetch (IF) and data memory (DM) requesters in the multi-cycle MIPS core.
- Registers the winning request and drives the select of the 32-bit 2:1 address/data muxes in front of the memory port (sel=0 IF, sel=1 DM).
- Sequences a fixed-latency access and returns read data with a one-cycle ack.

---
 rtl/mem_port_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/DM arbiter for a single-port unified memory with fixed-latency access
// Optional conflict counter port and logic are compiled in with MEM_ARB_PERF_EN.
module mem_port_arbiter #(
  parameter int WAIT_CYCLES  = 2,
  parameter int STARVE_LIMIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ack,
  output logic        sel,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [15:0] conflict_cnt
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [3:0] WAIT_LOAD  = 4'(WAIT_CYCLES - 1);
  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

  logic [1:0] state;
  logic [3:0] wait_cnt;
  logic [2:0] streak;
  logic       wflag;
  logic       grant_dm;
  logic       grant_if;

  // DM wins unless IF has already been passed over STARVE_LIMIT times in a row
  always_comb begin
    grant_dm = dm_req && !(if_req && (streak == STARVE_MAX));
    grant_if = !grant_dm && if_req;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      wait_cnt  <= 4'd0;
      streak    <= 3'd0;
      wflag     <= 1'b0;
      sel       <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      if_rdata  <= 32'd0;
      dm_rdata  <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_dm) begin
            sel       <= 1'b1;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            wflag     <= dm_we;
            wait_cnt  <= WAIT_LOAD;
            state     <= S_ACCESS;
            if (!if_req)
              streak <= 3'd0;
            else if (streak != STARVE_MAX)
              streak <= streak + 3'd1;
          end else if (grant_if) begin
            sel      <= 1'b0;
            mem_addr <= if_addr;
            wflag    <= 1'b0;
            wait_cnt <= WAIT_LOAD;
            state    <= S_ACCESS;
            streak   <= 3'd0;
          end
        end
        S_ACCESS: begin
          if (wait_cnt == 4'd0) begin
            if (!wflag) begin
              if (sel)
                dm_rdata <= mem_rdata;
              else
                if_rdata <= mem_rdata;
            end
            state <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes decode straight from state so reset clears them without extra flops
  always_comb begin
    mem_en = (state == S_ACCESS);
    mem_we = (state == S_ACCESS) && wflag;
    busy   = (state != S_IDLE);
    if_ack = (state == S_DONE) && !sel;
    dm_ack = (state == S_DONE) && sel;
  end

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      conflict_cnt <= 16'd0;
    else if ((state == S_IDLE) && if_req && dm_req && (conflict_cnt != 16'hFFFF))
      conflict_cnt <= conflict_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed table-driven bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_ack, dm_ack, sel, mem_en, mem_we, busy;

  logic        b_if_req;
  logic [31:0] b_if_addr, b_mem_rdata;
  logic [31:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata;
  logic        b_if_ack, b_dm_ack, b_sel, b_mem_en, b_mem_we, b_busy;

`ifdef MEM_ARB_PERF_EN
  logic [15:0] conflict_cnt, b_conflict_cnt;
`endif

  int nchk  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WAIT_CYCLES(2), .STARVE_LIMIT(2)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .sel(sel), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
`ifdef MEM_ARB_PERF_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  mem_port_arbiter #(.WAIT_CYCLES(1), .STARVE_LIMIT(2)) u_dut1 (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ack(b_if_ack),
    .dm_req(1'b0), .dm_we(1'b0), .dm_addr(32'd0), .dm_wdata(32'd0),
    .dm_rdata(b_dm_rdata), .dm_ack(b_dm_ack),
    .sel(b_sel), .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
`ifdef MEM_ARB_PERF_EN
    , .conflict_cnt(b_conflict_cnt)
`endif
  );

  typedef struct {
    string       name;
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] mem_rdata;
    logic        exp_sel;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_dm_rdata;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ack(output int cycles, output int en_cycles);
    cycles    = 1;
    en_cycles = 0;
    while (!(if_ack || dm_ack) && cycles < 20) begin
      if (mem_en) en_cycles++;
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int cyc, en;
    if_req    = v.if_req;    if_addr  = v.if_addr;
    dm_req    = v.dm_req;    dm_we    = v.dm_we;
    dm_addr   = v.dm_addr;   dm_wdata = v.dm_wdata;
    mem_rdata = v.mem_rdata;
    @(negedge clk);
    chk({v.name, " sel"},       32'(sel),    32'(v.exp_sel));
    chk({v.name, " mem_we"},    32'(mem_we), 32'(v.exp_we));
    chk({v.name, " mem_addr"},  mem_addr,    v.exp_addr);
    chk({v.name, " mem_wdata"}, mem_wdata,   v.exp_wdata);
    wait_ack(cyc, en);
    chk({v.name, " latency"},   32'(cyc),    32'd3);
    chk({v.name, " en_cycles"}, 32'(en),     32'd2);
    chk({v.name, " ack"},       32'({if_ack, dm_ack}), v.exp_sel ? 32'd1 : 32'd2);
    chk({v.name, " if_rdata"},  if_rdata,    v.exp_if_rdata);
    chk({v.name, " dm_rdata"},  dm_rdata,    v.exp_dm_rdata);
    chk({v.name, " done_en"},   32'(mem_en), 32'd0);
    if_req = 1'b0;
    dm_req = 1'b0;
    @(negedge clk);
    chk({v.name, " idle"},      32'({busy, if_ack, dm_ack}), 32'd0);
  endtask

  initial begin
    automatic bit exp_ord[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int cyc, en, dm_acks, ack1, ack2, en_cnt;
    logic bubble;

    vecs[0] = '{"if_read",   1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'h0, 32'h0, 32'h2408_0005,
                1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'h2408_0005, 32'h0};
    vecs[1] = '{"dm_store",  1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 32'h1111_1111,
                1'b1, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 32'h2408_0005, 32'h0};
    vecs[2] = '{"dm_load",   1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_2000, 32'h1234_5678, 32'hCAFE_F00D,
                1'b1, 1'b0, 32'h0000_2000, 32'h1234_5678, 32'h2408_0005, 32'hCAFE_F00D};
    vecs[3] = '{"if_read2",  1'b1, 32'h0000_0044, 1'b0, 1'b0, 32'h0, 32'h0, 32'h8C09_0004,
                1'b0, 1'b0, 32'h0000_0044, 32'h1234_5678, 32'h8C09_0004, 32'hCAFE_F00D};
    vecs[4] = '{"dm_store2", 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_3000, 32'hA5A5_A5A5, 32'hFFFF_FFFF,
                1'b1, 1'b1, 32'h0000_3000, 32'hA5A5_A5A5, 32'h8C09_0004, 32'hCAFE_F00D};

    rst = 1'b1;
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = 32'h0; dm_addr = 32'h0; dm_wdata = 32'h0; mem_rdata = 32'h0;
    b_if_req = 1'b0; b_if_addr = 32'h0; b_mem_rdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    chk("reset ctl",      32'({sel, mem_en, mem_we, if_ack, dm_ack, busy}), 32'd0);
    chk("reset mem_addr", mem_addr | mem_wdata, 32'd0);
    chk("reset rdata",    if_rdata | dm_rdata,  32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // both requesters held: streak forces IF every third grant
    if_req = 1'b1; if_addr = 32'h0000_0100;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0200; mem_rdata = 32'h0BAD_CAFE;
    for (int k = 0; k < 6; k++) begin
      wait_ack(cyc, en);
      chk($sformatf("starve ack%0d", k), 32'({if_ack, dm_ack}), exp_ord[k] ? 32'd1 : 32'd2);
`ifdef MEM_ARB_PERF_EN
      if (k == 5) chk("conflict_cnt", 32'(conflict_cnt), 32'd6);
`endif
      if (k == 5) begin
        if_req = 1'b0;
        dm_req = 1'b0;
      end
      @(negedge clk);
    end
    chk("starve idle", 32'(busy), 32'd0);

    // DM load whose request drops right after grant
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_5000; mem_rdata = 32'h600D_F00D;
    @(negedge clk);
    dm_req = 1'b0;
    dm_acks = 0;
    for (int i = 0; i < 6; i++) begin
      if (dm_ack) dm_acks++;
      @(negedge clk);
    end
    chk("drop dm_acks",  32'(dm_acks), 32'd1);
    chk("drop dm_rdata", dm_rdata, 32'h600D_F00D);
    chk("drop idle",     32'(busy), 32'd0);

    // reset during second ACCESS cycle of a store
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_4000; dm_wdata = 32'h55AA_55AA;
    @(negedge clk);
    @(negedge clk);
    chk("rst pre busy", 32'({busy, mem_we}), 32'd3);
    rst = 1'b1;
    #1;
    chk("rst async ctl",  32'({sel, mem_en, mem_we, if_ack, dm_ack, busy}), 32'd0);
    chk("rst async data", mem_addr | mem_wdata | if_rdata | dm_rdata, 32'd0);
    dm_req = 1'b0; dm_we = 1'b0;
    if_req = 1'b1; if_addr = 32'h0000_0080; mem_rdata = 32'h3C01_1234;
    @(negedge clk);
    chk("rst hold ack", 32'({if_ack, dm_ack}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst regrant", 32'({busy, sel}), 32'd2);
    chk("rst regrant addr", mem_addr, 32'h0000_0080);
    wait_ack(cyc, en);
    chk("rst if ack",   32'({if_ack, dm_ack}), 32'd2);
    chk("rst if_rdata", if_rdata, 32'h3C01_1234);
    if_req = 1'b0;
    @(negedge clk);

    // WAIT_CYCLES=1 instance: back-to-back IF reads
    b_if_req = 1'b1; b_if_addr = 32'h0; b_mem_rdata = 32'h0000_0001;
    ack1 = -1; ack2 = -1; en_cnt = 0; bubble = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (b_mem_en && ack2 < 0) en_cnt++;
      if (i == 2) bubble = b_busy;
      if (b_mem_en && ack1 >= 0 && ack2 < 0) chk("w1 addr2", b_mem_addr, 32'h4);
      if (b_if_ack) begin
        if (ack1 < 0) begin
          ack1 = i;
          chk("w1 rdata1", b_if_rdata, 32'h0000_0001);
          b_if_addr = 32'h4; b_mem_rdata = 32'h0000_0002;
        end else if (ack2 < 0) begin
          ack2 = i;
          chk("w1 rdata2", b_if_rdata, 32'h0000_0002);
          b_if_req = 1'b0;
        end
      end
    end
    chk("w1 ack1 cycle", 32'(ack1), 32'd1);
    chk("w1 ack spacing", 32'(ack2 - ack1), 32'd3);
    chk("w1 en cycles", 32'(en_cnt), 32'd2);
    chk("w1 bubble", 32'(bubble), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end

endmodule
